// File: rtl/hf_reader_seq.sv
// TX -> GUARD -> RX transaction sequencer driving minor_mode / mod_out of the HF reader.
// Optional: define HF_READER_SEQ_EARLY_EOF_EN to let rx_eof end the receive window early.
module hf_reader_seq #(
  parameter int unsigned GUARD_W = 16,
  parameter int unsigned RX_W    = 16
) (
  input  logic               ck_1356meg,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         tx_mode,
  input  logic [3:0]         rx_mode,
  input  logic [3:0]         idle_mode,
  input  logic [11:0]        tx_bits,
  input  logic [7:0]         tx_bit_clks,
  input  logic [GUARD_W-1:0] guard_clks,
  input  logic [RX_W-1:0]    rx_clks,
  input  logic               tx_bit,
  input  logic               tx_bit_valid,
  input  logic               rx_eof,
  output logic               tx_bit_ready,
  output logic               mod_out,
  output logic [3:0]         minor_mode,
  output logic               busy,
  output logic               rx_active,
  output logic               done,
  output logic               tx_underrun
);

  localparam logic [3:0] MODE_RECEIVE_IQ = 4'd0;

  typedef enum logic [1:0] {IDLE, TX, GUARD, RX} state_t;

  state_t             state, state_n;
  logic [3:0]         tx_mode_q, tx_mode_n;
  logic [3:0]         rx_mode_q, rx_mode_n;
  logic [7:0]         bit_clks_q, bit_clks_n;
  logic [7:0]         phase, phase_n;
  logic [11:0]        bits_left, bits_left_n;
  logic [GUARD_W-1:0] guard_cnt, guard_cnt_n;
  logic [RX_W-1:0]    rx_cnt, rx_cnt_n;

  logic               mod_n, ready_n, busy_n, rx_active_n, done_n, underrun_n;
  logic [3:0]         minor_n;
  logic               eof_hit;

`ifdef HF_READER_SEQ_EARLY_EOF_EN
  assign eof_hit = rx_eof;
`else
  logic unused_rx_eof;
  assign unused_rx_eof = rx_eof;
  assign eof_hit       = 1'b0;
`endif

  // Phase that follows TX, skipping any zero-length phases.
  function automatic state_t post_tx(input logic guard_zero, input logic rx_zero);
    if (!guard_zero)   return GUARD;
    else if (!rx_zero) return RX;
    else               return IDLE;
  endfunction

  always_comb begin
    state_n     = state;
    tx_mode_n   = tx_mode_q;
    rx_mode_n   = rx_mode_q;
    bit_clks_n  = bit_clks_q;
    phase_n     = phase;
    bits_left_n = bits_left;
    guard_cnt_n = guard_cnt;
    rx_cnt_n    = rx_cnt;
    mod_n       = 1'b0;
    ready_n     = 1'b0;
    done_n      = 1'b0;
    underrun_n  = tx_underrun;

    case (state)
      IDLE: begin
        if (start) begin
          tx_mode_n   = tx_mode;
          rx_mode_n   = rx_mode;
          bit_clks_n  = (tx_bit_clks == 8'd0) ? 8'd1 : tx_bit_clks;
          bits_left_n = tx_bits;
          guard_cnt_n = guard_clks;
          rx_cnt_n    = rx_clks;
          phase_n     = '0;
          underrun_n  = 1'b0;
          if (tx_bits != 12'd0) begin
            state_n = TX;
            ready_n = 1'b1;
          end else begin
            state_n = post_tx(guard_clks == '0, rx_clks == '0);
            done_n  = (state_n == IDLE);
          end
        end
      end

      TX: begin
        phase_n = (phase == bit_clks_q - 8'd1) ? 8'd0 : phase + 8'd1;
        if (tx_bit_ready) begin
          if (!tx_bit_valid) begin
            underrun_n = 1'b1;
            state_n    = IDLE;
            done_n     = 1'b1;
          end else begin
            mod_n       = tx_bit;
            bits_left_n = bits_left - 12'd1;
            ready_n     = (phase_n == 8'd0) && (bits_left_n != 12'd0);
          end
        end else if (phase == 8'd0) begin
          // Boundary with no bit left: the last bit period has just ended.
          state_n = post_tx(guard_cnt == '0, rx_cnt == '0);
          done_n  = (state_n == IDLE);
        end else begin
          mod_n   = mod_out;
          ready_n = (phase_n == 8'd0) && (bits_left != 12'd0);
        end
      end

      GUARD: begin
        guard_cnt_n = guard_cnt - GUARD_W'(1);
        if (guard_cnt == GUARD_W'(1)) begin
          state_n = (rx_cnt != '0) ? RX : IDLE;
          done_n  = (rx_cnt == '0);
        end
      end

      RX: begin
        rx_cnt_n = rx_cnt - RX_W'(1);
        if (eof_hit || rx_cnt == RX_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    if (state != IDLE && abort) begin
      state_n    = IDLE;
      mod_n      = 1'b0;
      ready_n    = 1'b0;
      done_n     = 1'b0;
      underrun_n = tx_underrun;
    end

    busy_n      = (state_n != IDLE);
    rx_active_n = (state_n == RX);
    case (state_n)
      TX:          minor_n = tx_mode_n;
      GUARD, RX:   minor_n = rx_mode_n;
      default:     minor_n = idle_mode;
    endcase
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      state        <= IDLE;
      tx_mode_q    <= '0;
      rx_mode_q    <= '0;
      bit_clks_q   <= 8'd1;
      phase        <= '0;
      bits_left    <= '0;
      guard_cnt    <= '0;
      rx_cnt       <= '0;
      mod_out      <= 1'b0;
      tx_bit_ready <= 1'b0;
      busy         <= 1'b0;
      rx_active    <= 1'b0;
      done         <= 1'b0;
      tx_underrun  <= 1'b0;
      minor_mode   <= MODE_RECEIVE_IQ;
    end else begin
      state        <= state_n;
      tx_mode_q    <= tx_mode_n;
      rx_mode_q    <= rx_mode_n;
      bit_clks_q   <= bit_clks_n;
      phase        <= phase_n;
      bits_left    <= bits_left_n;
      guard_cnt    <= guard_cnt_n;
      rx_cnt       <= rx_cnt_n;
      mod_out      <= mod_n;
      tx_bit_ready <= ready_n;
      busy         <= busy_n;
      rx_active    <= rx_active_n;
      done         <= done_n;
      tx_underrun  <= underrun_n;
      minor_mode   <= minor_n;
    end
  end

endmodule

// File: doc/hf_reader_seq.md
# hf_reader_seq

Transaction sequencer for the HF reader datapath. Runs one reader exchange per `start`:
- **TX:** transmit a bit stream from the ARM.
- **GUARD:** wait a programmable guard time.
- **RX:** open a receive window.

It drives the `minor_mode` and modulation (`ssp_dout`-equivalent) inputs of the HF reader correlator/modulator, so the ARM does not have to time mode switches in firmware. It sits between the ARM-side config/FIFO logic and the HF reader block, in the 13.56 MHz domain.

## Interface
Parameters:
- `GUARD_W`, 16: width of the guard-time counter, in carrier cycles.
- `RX_W`, 16: width of the receive-window counter, in carrier cycles.

Ports:
- `ck_1356meg` in 1: 13.56 MHz carrier clock. The only clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request to begin a transaction. Honoured only in IDLE.
- `abort` in 1: terminate the current transaction.
- `tx_mode` in 4: minor mode used during TX (`FPGA_HF_READER_MODE_SEND_FULL_MOD` / `_SHALLOW_MOD` / `_SHALLOW_MOD_RDV4`).
- `rx_mode` in 4: minor mode used during GUARD and RX (`_RECEIVE_IQ` / `_RECEIVE_AMPLITUDE`).
- `idle_mode` in 4: minor mode used while IDLE.
- `tx_bits` in 12: number of bits to transmit.
- `tx_bit_clks` in 8: carrier cycles per bit. 0 is treated as 1.
- `guard_clks` in `GUARD_W`: guard length.
- `rx_clks` in `RX_W`: receive-window length.
- `tx_bit` in 1: data bit.
- `tx_bit_valid` in 1: `tx_bit` is available.
- `rx_eof` in 1: end-of-frame pulse from the decoder. Used only with the config macro.
- `tx_bit_ready` out 1: a bit is accepted in this cycle if `tx_bit_valid` is high.
- `mod_out` out 1: modulation bit to the HF reader. 1 = modulate.
- `minor_mode` out 4: mode to the HF reader.
- `busy` out 1: state is not IDLE.
- `rx_active` out 1: state is RX.
- `done` out 1: one-cycle completion pulse.
- `tx_underrun` out 1: sticky error flag. Cleared on an accepted `start`.

## Operation
- **States:** IDLE, TX, GUARD, RX.
- **Latching:** an accepted `start` latches all length and mode inputs. Later input changes have no effect until the next `start`.
- **IDLE:**
  - `minor_mode` = `idle_mode` (registered).
  - `mod_out` = 0.
  - On `start`, the next state is TX. If `tx_bits` = 0 it is GUARD instead; if `guard_clks` is also 0 it is RX; if `rx_clks` is also 0 the transaction completes immediately.
- **TX:**
  - `minor_mode` = `tx_mode`.
  - `tx_bit_ready` is high for exactly one cycle at each bit boundary: the first TX cycle, then every `tx_bit_clks` cycles.
  - An accepted bit drives `mod_out` from the next cycle for `tx_bit_clks` cycles.
  - After the last bit period, go to GUARD (or RX, or completion, if the following lengths are 0).
- **Underrun:** `tx_bit_valid` = 0 while `tx_bit_ready` = 1 means:
  - set `tx_underrun`;
  - `mod_out` goes to 0;
  - go to IDLE;
  - pulse `done`.
- **GUARD:** `minor_mode` = `rx_mode`, `mod_out` = 0, count `guard_clks` cycles, then go to RX.
- **RX:** `minor_mode` = `rx_mode`, `rx_active` = 1, count `rx_clks` cycles, then go to IDLE and pulse `done`.
- **Abort:** `abort` in any non-IDLE state means:
  - next cycle is IDLE;
  - `mod_out` = 0;
  - no `done` pulse;
  - `tx_underrun` unchanged.
- **Simultaneous events:** `abort` beats underrun and normal completion. `start` is ignored while `busy`. `start` and `abort` together in IDLE: `start` wins.
- **Counters:** all counters are unsigned and saturate-free. Terminal counts are compared exactly, with no wrap.

## Timing
- **Reset values:**
  - state IDLE;
  - `minor_mode` = `FPGA_HF_READER_MODE_RECEIVE_IQ`;
  - `mod_out`, `tx_bit_ready`, `busy`, `rx_active`, `done`, `tx_underrun` all 0.
- **Reset mid-transaction:** behaves exactly like reset from idle. No `done`.
- **All outputs are registered.** Bit-accept cycles are timed against `start` at cycle T0:
  - T1 is the first TX cycle, with `busy` = 1 and `tx_bit_ready` = 1.
  - Bit k is accepted at T1 + k·C, where C = `tx_bit_clks`.
  - Bit k drives `mod_out` during T2 + k·C … T1 + (k+1)·C.
- **Phase boundaries** (N = `tx_bits`, G = `guard_clks`, R = `rx_clks`):
  - GUARD occupies T1 + N·C + 1 … T1 + N·C + G.
  - RX occupies the next R cycles.
  - `done` is asserted in the first IDLE cycle after RX.
- **Mode switching:** `minor_mode` changes in the same cycle as the state change.

## Configuration
- **`HF_READER_SEQ_EARLY_EOF_EN` defined:** a `rx_eof` pulse in RX ends the window. The next cycle is IDLE with `done` = 1.
- **Not defined:** `rx_eof` is ignored and RX always lasts `rx_clks` cycles.

## Test plan
- **Normal transaction:** `tx_bits`=4, C=2, G=3, R=5, bits 1,0,1,1 → `mod_out` 1,1,0,0,1,1,1,1 over T2..T9; GUARD T10–12; `rx_active` T13–17; `done` at T18.
- **Underrun:** valid dropped at the 3rd bit boundary (T5, C=2) → `tx_underrun`=1, `done` at T6, IDLE, `minor_mode`=`idle_mode`.
- **Zero lengths:** `tx_bits`=0, G=0, R=4 → `rx_active` T1–T4, `done` T5, `tx_bit_ready` never asserted.
- **Abort:** `abort` in GUARD → IDLE next cycle, no `done`, `mod_out`=0. `start` during `busy` → no effect.
- **Early EOF:** macro on, `rx_eof` at RX cycle 2 of R=100 → `done` next cycle. Macro off → `done` after 100 cycles.
- **Reset mid-TX:** → all outputs at reset values on the next edge; a new `start` runs normally.
